spi_mem_ctrl: RTL and testbench

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

---
 rtl/spi_mem_ctrl_pkg.sv | 20 ++
 rtl/spi_word_serializer.sv | 56 +++++
 rtl/spi_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_ctrl_pkg.sv
// Shared types and constants for the SPI-slave memory bridge.
package spi_mem_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WR_DATA,
    ST_WR_MEM,
    ST_RD_MEM,
    ST_RD_CAP,
    ST_RD_SEND,
    ST_DISCARD
  } state_e;

  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [1:0] DLEN_WORD = 2'b11;

endpackage

// File: rtl/spi_word_serializer.sv
// Splits a 32-bit word into four bytes, LSB first, over a valid/ready handshake.
module spi_word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        clear,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        done
);

  logic [31:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic        hs;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    hs    = vld_q & tx_ready;
    done  = hs && (cnt_q == 2'd3);
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else if (load) begin
      sr_d  = load_data;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (hs) begin
      // byte only advances on a completed handshake, so it holds while stalled
      sr_d  = {8'h00, sr_q[31:8]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign tx_valid = vld_q;
  assign tx_byte  = sr_q[7:0];

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI-slave byte protocol to word-memory bridge: opcode, 16-bit address, then burst data.
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      core_select,
  input  logic                      frame_active,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic                      tx_valid,
  output logic [7:0]                tx_byte,
  input  logic                      tx_ready,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDRESS_LENGTH-1:0] mem_address,
  output logic [DATA_LENGTH-1:0]    mem_data_out,
  output logic [1:0]                mem_data_length,
  input  logic [DATA_LENGTH-1:0]    mem_data_in,
  output logic                      busy,
  output logic                      err
);

  localparam logic [ADDRESS_LENGTH-1:0] ADDR_ONE = 1;

  state_e                    state_q, state_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic [7:0]                hi_q, hi_d;
  logic [DATA_LENGTH-1:0]    wr_sr_q, wr_sr_d;
  logic [1:0]                bcnt_q, bcnt_d;
  logic                      is_rd_q, is_rd_d;
  logic                      err_q, err_d;
  logic                      wr_stb, rd_stb, ser_load, ser_done;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    wr_sr_d  = wr_sr_q;
    bcnt_d   = bcnt_q;
    is_rd_d  = is_rd_q;
    err_d    = 1'b0;
    wr_stb   = 1'b0;
    rd_stb   = 1'b0;
    ser_load = 1'b0;
    // a dropped chip-select wins over everything, so no strobe can leak out
    if (!frame_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          if (rx_byte == OPC_WRITE || rx_byte == OPC_READ) begin
            is_rd_d = (rx_byte == OPC_READ);
            state_d = ST_ADDR_HI;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end
        ST_ADDR_HI: if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: if (rx_valid) begin
          addr_d  = ADDRESS_LENGTH'({hi_q, rx_byte});
          bcnt_d  = '0;
          state_d = is_rd_q ? ST_RD_MEM : ST_WR_DATA;
        end
        ST_WR_DATA: if (rx_valid) begin
          wr_sr_d = {rx_byte, wr_sr_q[DATA_LENGTH-1:8]};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = ST_WR_MEM;
        end
        ST_WR_MEM: begin
          if (rx_valid) err_d = 1'b1;
          if (!core_select) begin
            wr_stb  = 1'b1;
            addr_d  = addr_q + ADDR_ONE;
            state_d = ST_WR_DATA;
          end
        end
        ST_RD_MEM: if (!core_select) begin
          rd_stb  = 1'b1;
          state_d = ST_RD_CAP;
        end
        ST_RD_CAP: begin
          ser_load = 1'b1;
          state_d  = ST_RD_SEND;
        end
        ST_RD_SEND: if (ser_done) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = ST_RD_MEM;
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      wr_sr_q <= '0;
      bcnt_q  <= '0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      wr_sr_q <= wr_sr_d;
      bcnt_q  <= bcnt_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
    end
  end

  spi_word_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (mem_data_in),
    .clear     (!frame_active),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .done      (ser_done)
  );

  assign mem_en          = wr_stb | rd_stb;
  assign mem_wr_en       = wr_stb;
  assign mem_rd_en       = rd_stb;
  assign mem_address     = addr_q;
  assign mem_data_out    = wr_sr_q;
  assign mem_data_length = DLEN_WORD;
  assign busy            = (state_q != ST_IDLE);
  assign err             = err_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl: write vector table plus read, stall, abort and reset sequences.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_select = 1'b0;
  logic        frame_active = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        mem_en, mem_wr_en, mem_rd_en;
  logic [10:0] mem_address;
  logic [31:0] mem_data_out;
  logic [1:0]  mem_data_length;
  logic [31:0] mem_data_in = 32'h0;
  logic        busy, err;

  spi_mem_ctrl #(.DATA_LENGTH(32), .ADDRESS_LENGTH(11)) dut (
    .clk(clk), .rst(rst), .core_select(core_select), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_length(mem_data_length), .mem_data_in(mem_data_in),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_model [0:2047];
  logic [10:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic [10:0] rd_addr_log [$];
  logic [7:0]  tx_log [$];
  int          err_cnt = 0, sel_viol = 0, stab_viol = 0;
  bit          stab_en = 1'b0;
  logic        prev_vld = 1'b0, prev_hs = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  int          errors = 0, checks = 0;

  always @(posedge clk) begin
    if (mem_en && mem_wr_en) begin
      wr_addr_log.push_back(mem_address);
      wr_data_log.push_back(mem_data_out);
    end
    if (mem_en && mem_rd_en) begin
      rd_addr_log.push_back(mem_address);
      mem_data_in <= mem_model[mem_address];
    end
    if (mem_en && core_select) sel_viol <= sel_viol + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (tx_valid && tx_ready) tx_log.push_back(tx_byte);
    if (stab_en && prev_vld && !prev_hs && (!tx_valid || tx_byte != prev_byte))
      stab_viol <= stab_viol + 1;
    prev_vld  <= tx_valid;
    prev_hs   <= tx_valid && tx_ready;
    prev_byte <= tx_byte;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic write_frame(input logic [7:0] ahi, input logic [7:0] alo, input logic [31:0] w);
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h02); send(ahi); send(alo);
    send_word(w);
    tick(3);
    frame_active = 1'b0;
    tick(2);
  endtask

  function automatic logic [31:0] wa(input int i);
    return (wr_addr_log.size() > i) ? 32'(wr_addr_log[i]) : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] wd(input int i);
    return (wr_data_log.size() > i) ? wr_data_log[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] ra(input int i);
    return (rd_addr_log.size() > i) ? 32'(rd_addr_log[i]) : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] tb(input int i);
    return (tx_log.size() > i) ? 32'(tx_log[i]) : 32'hxxxxxxxx;
  endfunction

  typedef struct {
    logic [7:0]  ahi;
    logic [7:0]  alo;
    logic [31:0] data;
    logic [10:0] exp_addr;
  } wvec_t;

  initial begin
    wvec_t vecs [4];
    int    n0, e0, r0;

    vecs[0] = '{8'h00, 8'h10, 32'hDEADBEEF, 11'h010};
    vecs[1] = '{8'hFF, 8'hFF, 32'h01020304, 11'h7FF};
    vecs[2] = '{8'h08, 8'h05, 32'hA5A55A5A, 11'h005};
    vecs[3] = '{8'h03, 8'h00, 32'hFFFFFFFF, 11'h300};
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    mem_model[4] = 32'h12345678;
    mem_model[5] = 32'h9ABCDEF0;
    mem_model[8] = 32'hCAFEF00D;

    // reset state
    tick(2);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_en", 32'({mem_en, mem_wr_en, mem_rd_en}), 0);
    check("rst_data_out", mem_data_out, 0);
    check("rst_address", 32'(mem_address), 0);
    check("rst_dlen", 32'(mem_data_length), 32'h3);
    rst = 1'b0;

    // write vector table; the first one is the first frame after reset
    for (int v = 0; v < 4; v++) begin
      n0 = wr_addr_log.size();
      write_frame(vecs[v].ahi, vecs[v].alo, vecs[v].data);
      check($sformatf("wr%0d_count", v), 32'(wr_addr_log.size()), 32'(n0 + 1));
      check($sformatf("wr%0d_addr", v), wa(n0), 32'(vecs[v].exp_addr));
      check($sformatf("wr%0d_data", v), wd(n0), vecs[v].data);
      check($sformatf("wr%0d_busy_after", v), 32'(busy), 0);
    end

    // two-word burst wrapping past the top address
    n0 = wr_addr_log.size();
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h02); send(8'h07); send(8'hFF);
    send_word(32'h11112222);
    send_word(32'h33334444);
    tick(3);
    frame_active = 1'b0;
    tick(2);
    check("wrap_count", 32'(wr_addr_log.size()), 32'(n0 + 2));
    check("wrap_addr0", wa(n0), 32'h7FF);
    check("wrap_addr1", wa(n0 + 1), 32'h000);
    check("wrap_data1", wd(n0 + 1), 32'h33334444);

    // read with a throttled consumer and a dummy clocking byte
    e0 = err_cnt;
    r0 = rd_addr_log.size();
    tx_log.delete();
    stab_en = 1'b1;
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h03); send(8'h00); send(8'h04);
    send(8'h00);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tx_ready = ~tx_ready;
      if (tx_log.size() >= 4 && rd_addr_log.size() >= r0 + 2) break;
    end
    tx_ready = 1'b0;
    stab_en  = 1'b0;
    @(negedge clk);
    frame_active = 1'b0;
    tick(2);
    check("rd_byte0", tb(0), 32'h78);
    check("rd_byte1", tb(1), 32'h56);
    check("rd_byte2", tb(2), 32'h34);
    check("rd_byte3", tb(3), 32'h12);
    check("rd_addr0", ra(r0), 32'h004);
    check("rd_addr1", ra(r0 + 1), 32'h005);
    check("rd_stable", 32'(stab_viol), 0);
    check("rd_dummy_no_err", 32'(err_cnt), 32'(e0));

    // core owns the memory for 20 cycles with a complete word pending
    n0 = wr_addr_log.size();
    e0 = err_cnt;
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h02); send(8'h00); send(8'h20);
    send(8'h11); send(8'h22); send(8'h33);
    core_select = 1'b1;
    send(8'h44);
    tick(6);
    send(8'hAA);
    tick(12);
    check("stall_no_write", 32'(wr_addr_log.size()), 32'(n0));
    check("stall_overrun_err", 32'(err_cnt), 32'(e0 + 1));
    core_select = 1'b0;
    @(negedge clk);
    check("stall_release_write", 32'(wr_addr_log.size()), 32'(n0 + 1));
    check("stall_addr", wa(n0), 32'h020);
    check("stall_data", wd(n0), 32'h44332211);
    frame_active = 1'b0;
    tick(2);
    check("stall_sel_viol", 32'(sel_viol), 0);

    // abort after 3 of 4 data bytes
    n0 = wr_addr_log.size();
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h02); send(8'h00); send(8'h30);
    send(8'h01); send(8'h02); send(8'h03);
    frame_active = 1'b0;
    tick(3);
    check("abort3_no_write", 32'(wr_addr_log.size()), 32'(n0));
    check("abort3_idle", 32'(busy), 0);

    // chip-select drops in the very cycle the write would strobe
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h02); send(8'h00); send(8'h31);
    send(8'h01); send(8'h02); send(8'h03);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h04;
    @(negedge clk);
    rx_valid = 1'b0;
    frame_active = 1'b0;
    tick(3);
    check("abort_edge_no_write", 32'(wr_addr_log.size()), 32'(n0));

    // bad opcode: one error, remainder discarded
    e0 = err_cnt;
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h55); send(8'h02); send(8'h00); send(8'h10);
    send_word(32'h01010101);
    tick(2);
    check("badop_busy", 32'(busy), 1);
    frame_active = 1'b0;
    tick(2);
    check("badop_err_once", 32'(err_cnt), 32'(e0 + 1));
    check("badop_no_write", 32'(wr_addr_log.size()), 32'(n0));
    check("badop_idle", 32'(busy), 0);

    // asynchronous reset while a read word is waiting for its consumer
    @(negedge clk);
    frame_active = 1'b1;
    send(8'h03); send(8'h00); send(8'h08);
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    check("rstmid_in_send", 32'(tx_valid), 1);
    check("rstmid_first_byte", 32'(tx_byte), 32'h0D);
    #2;
    rst = 1'b1;
    frame_active = 1'b0;
    #1;
    check("rstmid_tx_valid", 32'(tx_valid), 0);
    check("rstmid_strobes", 32'({mem_en, mem_wr_en, mem_rd_en}), 0);
    check("rstmid_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = wr_addr_log.size();
    write_frame(8'h00, 8'h40, 32'h0BADF00D);
    check("post_rst_count", 32'(wr_addr_log.size()), 32'(n0 + 1));
    check("post_rst_addr", wa(n0), 32'h040);
    check("post_rst_data", wd(n0), 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
